// File: rtl/mem_stage.sv
// RV32I memory-access stage: byte-serial little-endian loads/stores with registered write-back.
// Optional MEM_MISALIGN_TRAP_EN: misaligned H/W accesses are dropped and flagged on misalign.
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        memop,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       sdata,
  input  logic [4:0]        waddr_i,
  input  logic              we_i,
  input  logic [31:0]       wdata_i,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic              ram_ack,
  input  logic [7:0]        ram_rdata,
  output logic [4:0]        waddr_o,
  output logic              we_o,
  output logic [31:0]       wdata_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  localparam logic [3:0] MO_LB  = 4'd1;
  localparam logic [3:0] MO_LH  = 4'd2;
  localparam logic [3:0] MO_LW  = 4'd3;
  localparam logic [3:0] MO_LBU = 4'd4;
  localparam logic [3:0] MO_LHU = 4'd5;
  localparam logic [3:0] MO_SB  = 4'd6;
  localparam logic [3:0] MO_SH  = 4'd7;
  localparam logic [3:0] MO_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t             state_reg, state_next;
  logic [3:0]         op_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [31:0]        sdata_reg;
  logic [4:0]         waddr_reg;
  logic               we_reg;
  logic [1:0]         cnt_reg;
  logic [1:0]         cnt_next;
  logic [31:0]        asm_reg;
  logic [31:0]        load_ext;
  logic [7:0]         sdata_byte [4];

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= MO_LB) && (op <= MO_LHU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op >= MO_SB) && (op <= MO_SW);
  endfunction

  // Index of the final byte: 0 for byte, 1 for halfword, 3 for word accesses.
  function automatic logic [1:0] op_last(input logic [3:0] op);
    case (op)
      MO_LH, MO_LHU, MO_SH: return 2'd1;
      MO_LW, MO_SW:         return 2'd3;
      default:              return 2'd0;
    endcase
  endfunction

  logic in_mem, in_misaligned, accept_mem, xfer_last;

  assign in_mem = op_is_load(memop) || op_is_store(memop);
`ifdef MEM_MISALIGN_TRAP_EN
  assign in_misaligned = ((op_last(memop) == 2'd1) && addr[0]) ||
                         ((op_last(memop) == 2'd3) && (addr[1:0] != 2'b00));
`else
  assign in_misaligned = 1'b0;
`endif
  assign accept_mem = in_valid && in_mem && !in_misaligned;
  assign xfer_last  = (cnt_reg == op_last(op_reg));
  assign cnt_next   = cnt_reg + 2'd1;

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbyte
    assign sdata_byte[gi] = sdata_reg[8*gi +: 8];
  end

  always_comb begin
    load_ext = asm_reg;
    case (op_reg)
      MO_LB:   load_ext = {{24{asm_reg[7]}}, asm_reg[7:0]};
      MO_LBU:  load_ext = {24'd0, asm_reg[7:0]};
      MO_LH:   load_ext = {{16{asm_reg[15]}}, asm_reg[15:0]};
      MO_LHU:  load_ext = {16'd0, asm_reg[15:0]};
      default: load_ext = asm_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept_mem) state_next = XFER;
      XFER:    if (ram_ack && xfer_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_reg == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg    <= '0;
      addr_reg  <= '0;
      sdata_reg <= '0;
      waddr_reg <= '0;
      we_reg    <= 1'b0;
      cnt_reg   <= '0;
      asm_reg   <= '0;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      waddr_o   <= '0;
      we_o      <= 1'b0;
      wdata_o   <= '0;
    end else begin
      we_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid && !in_mem) begin
            waddr_o <= waddr_i;
            we_o    <= we_i;
            wdata_o <= wdata_i;
          end else if (accept_mem) begin
            op_reg    <= memop;
            addr_reg  <= addr;
            sdata_reg <= sdata;
            waddr_reg <= waddr_i;
            we_reg    <= we_i;
            cnt_reg   <= '0;
            ram_req   <= 1'b1;
            ram_we    <= op_is_store(memop);
            ram_addr  <= addr;
            ram_wdata <= sdata[7:0];
          end
        end
        XFER: begin
          // RAM outputs only move on an ack, so they hold steady through wait states.
          if (ram_ack) begin
            if (op_is_load(op_reg)) asm_reg[8*cnt_reg +: 8] <= ram_rdata;
            cnt_reg <= cnt_next;
            if (xfer_last) begin
              ram_req <= 1'b0;
            end else begin
              ram_addr  <= addr_reg + ADDR_W'(cnt_next);
              ram_wdata <= sdata_byte[cnt_next];
            end
          end
        end
        DONE: begin
          if (op_is_load(op_reg)) begin
            waddr_o <= waddr_reg;
            we_o    <= we_reg;
            wdata_o <= load_ext;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= (state_reg == IDLE) && in_valid && in_mem && in_misaligned;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized ops against a byte-array RAM model.
module tb_mem_stage;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        memop;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       sdata;
  logic [4:0]        waddr_i;
  logic              we_i;
  logic [31:0]       wdata_i;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              ram_ack;
  logic [7:0]        ram_rdata;
  logic [4:0]        waddr_o;
  logic              we_o;
  logic [31:0]       wdata_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              misalign;
`endif

  mem_stage #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .memop(memop), .addr(addr), .sdata(sdata),
    .waddr_i(waddr_i), .we_i(we_i), .wdata_i(wdata_i),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .waddr_o(waddr_o), .we_o(we_o), .wdata_o(wdata_o)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] mem_model [int unsigned];

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (!mem_model.exists(a)) mem_model[a] = 8'($urandom);
    return mem_model[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one instruction at a negedge and follow it to retirement, playing the RAM.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] wa, input logic we, input logic [31:0] wd, input int wt);
    bit ld, st;
    int nb, cyc;
    logic [31:0] val, expv;
    logic [7:0] b;
    ld = (op >= 4'd1) && (op <= 4'd5);
    st = (op >= 4'd6) && (op <= 4'd8);
    nb = (op == 4'd1 || op == 4'd4 || op == 4'd6) ? 1 :
         (op == 4'd2 || op == 4'd5 || op == 4'd7) ? 2 : 4;
    chk("in_ready_before_issue", 32'(in_ready), 32'd1);
    memop = op; addr = a; sdata = sd; waddr_i = wa; we_i = we; wdata_i = wd;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; memop = 4'd0;
    $display("op=%0d addr=0x%08h sdata=0x%08h rd=%0d we=%0d wait=%0d", op, a, sd, wa, we, wt);
    if (!ld && !st) begin
      chk("nonmem_we_o", 32'(we_o), 32'(we));
      chk("nonmem_waddr_o", 32'(waddr_o), 32'(wa));
      chk("nonmem_wdata_o", wdata_o, wd);
      return;
    end
`ifdef MEM_MISALIGN_TRAP_EN
    if ((nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00)) begin
      chk("trap_misalign_pulse", 32'(misalign), 32'd1);
      chk("trap_we_o", 32'(we_o), 32'd0);
      chk("trap_ram_req", 32'(ram_req), 32'd0);
      chk("trap_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      chk("trap_misalign_end", 32'(misalign), 32'd0);
      chk("trap_ram_req_after", 32'(ram_req), 32'd0);
      return;
    end
`endif
    cyc = 1;
    val = 32'd0;
    for (int k = 0; k < nb; k++) begin
      for (int w = 0; w <= wt; w++) begin
        chk("xfer_ram_req", 32'(ram_req), 32'd1);
        chk("xfer_ram_we", 32'(ram_we), 32'(st));
        chk("xfer_ram_addr", ram_addr, a + 32'(k));
        if (st) chk("xfer_ram_wdata", 32'(ram_wdata), 32'(sd >> (8 * k)) & 32'hFF);
        chk("xfer_in_ready", 32'(in_ready), 32'd0);
        chk("xfer_we_o", 32'(we_o), 32'd0);
        if (w == wt) begin
          ram_ack = 1'b1;
          if (st) begin
            b = 8'(sd >> (8 * k));
            mem_model[a + 32'(k)] = b;
            ram_rdata = 8'($urandom);
          end else begin
            b = mem_rd(a + 32'(k));
            ram_rdata = b;
            val = val + (32'(b) << (8 * k));
          end
        end else begin
          ram_ack = 1'b0;
          ram_rdata = 8'($urandom);
        end
        @(negedge clk);
        ram_ack = 1'b0;
        cyc++;
      end
    end
    chk("done_ram_req", 32'(ram_req), 32'd0);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("done_we_o", 32'(we_o), 32'd0);
    @(negedge clk);
    cyc++;
    case (op)
      4'd1:    expv = (val >= 32'd128)   ? val - 32'd256   : val;
      4'd2:    expv = (val >= 32'd32768) ? val - 32'd65536 : val;
      default: expv = val;
    endcase
    chk("retire_latency", 32'(cyc), 32'(nb * (wt + 1) + 2));
    chk("retire_we_o", 32'(we_o), ld ? 32'(we) : 32'd0);
    chk("retire_in_ready", 32'(in_ready), 32'd1);
    if (ld) begin
      chk("retire_wdata_o", wdata_o, expv);
      chk("retire_waddr_o", 32'(waddr_o), 32'(wa));
    end
    @(negedge clk);
    chk("we_o_single_pulse", 32'(we_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; memop = 4'd0; addr = '0; sdata = '0;
    waddr_i = '0; we_i = 1'b0; wdata_i = '0; ram_ack = 1'b0; ram_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_ram_req", 32'(ram_req), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_waddr_o", 32'(waddr_o), 32'd0);
    chk("rst_we_o", 32'(we_o), 32'd0);
    chk("rst_wdata_o", wdata_o, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("rst_misalign", 32'(misalign), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Stray ack while idle must not start anything.
    ram_ack = 1'b1;
    @(negedge clk);
    ram_ack = 1'b0;
    chk("idle_ack_ram_req", 32'(ram_req), 32'd0);
    chk("idle_ack_in_ready", 32'(in_ready), 32'd1);

    do_op(4'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234_5678, 0);
    @(negedge clk);
    chk("nonmem_we_o_drops", 32'(we_o), 32'd0);
    chk("nonmem_wdata_o_holds", wdata_o, 32'h1234_5678);

    do_op(4'd8, 32'h100, 32'hAABB_CCDD, 5'd7, 1'b1, 32'h0, 0);

    mem_model[32'h200] = 8'h80;
    mem_model[32'h210] = 8'h34;
    mem_model[32'h211] = 8'h92;
    do_op(4'd1, 32'h200, 32'h0, 5'd3, 1'b1, 32'h0, 0);
    chk("lb_0x80_const", wdata_o, 32'hFFFF_FF80);
    do_op(4'd4, 32'h200, 32'h0, 5'd3, 1'b1, 32'h0, 0);
    chk("lbu_0x80_const", wdata_o, 32'h0000_0080);
    do_op(4'd2, 32'h210, 32'h0, 5'd4, 1'b1, 32'h0, 0);
    chk("lh_9234_const", wdata_o, 32'hFFFF_9234);

    mem_model[32'h400] = 8'h11; mem_model[32'h401] = 8'h22;
    mem_model[32'h402] = 8'h33; mem_model[32'h403] = 8'h44;
    do_op(4'd3, 32'h400, 32'h0, 5'd9, 1'b1, 32'h0, 2);
    chk("lw_slow_const", wdata_o, 32'h4433_2211);

    // Reset in the middle of a store: first byte lands, the rest is abandoned.
    memop = 4'd8; addr = 32'h300; sdata = 32'h5566_7788; waddr_i = 5'd1; we_i = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; memop = 4'd0;
    ram_ack = 1'b1;
    mem_model[32'h300] = 8'h88;
    @(negedge clk);
    ram_ack = 1'b0;
    chk("rst_mid_addr_advanced", ram_addr, 32'h301);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("reset during SW at 0x300 after byte 0");
    chk("rst_mid_ram_req", 32'(ram_req), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_we_o", 32'(we_o), 32'd0);
    do_op(4'd1, 32'h300, 32'h0, 5'd2, 1'b1, 32'h0, 1);
    chk("lb_after_rst_const", wdata_o, 32'hFFFF_FF88);

    do_op(4'd3, 32'h102, 32'h0, 5'd6, 1'b1, 32'h0, 0);
    do_op(4'd3, 32'hFFFF_FFFE, 32'h0, 5'd8, 1'b1, 32'h0, 0);
    do_op(4'd3, 32'h500, 32'h0, 5'd0, 1'b1, 32'h0, 0);

    for (int i = 0; i < 80; i++) begin
      do_op(4'($urandom_range(0, 15)), 32'h1000 + 32'($urandom_range(0, 31)), $urandom,
            5'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the RV32I pipeline, directly downstream of the execute stage. It receives the ALU result, destination register and write enable, plus a load/store descriptor. It performs the access over a byte-wide RAM port as a multi-cycle little-endian transfer, stalling upstream while busy. It presents registered write-back data to the register file.

## Interface
Parameters:
- ADDR_W, default 32: byte address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  stage can accept; low while an access is in flight
- memop  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
- addr  in  ADDR_W  effective address, i.e. the execute stage's result
- sdata  in  32  store data (rs2)
- waddr_i  in  5  destination register
- we_i  in  1  destination write enable
- wdata_i  in  32  execute-stage result
- ram_req  out  1  byte request valid
- ram_we  out  1  1 store byte, 0 load byte
- ram_addr  out  ADDR_W  byte address
- ram_wdata  out  8  store byte
- ram_ack  in  1  RAM accepted/completed the current byte; ram_rdata valid this cycle
- ram_rdata  in  8  load byte
- waddr_o  out  5  registered destination
- we_o  out  1  register-file write strobe, one cycle per retiring write
- wdata_o  out  32  registered write-back data
- misalign  out  1  present only with MEM_MISALIGN_TRAP_EN; one-cycle pulse

## Operation
- The FSM has three states: IDLE, XFER and DONE. The byte counter cnt is 2 bits and the byte count nbytes is 1, 2 or 4 (B, H, W).
- IDLE: in_ready=1.
  - in_valid with memop NONE: latch waddr_i, we_i and wdata_i to the outputs next cycle; stay in IDLE.
  - in_valid with load or store: capture memop, addr, sdata, waddr_i and we_i; cnt=0; go to XFER.
- XFER: in_ready=0. ram_req=1, ram_addr=addr+cnt (wraps modulo 2^ADDR_W), ram_we=store, ram_wdata=sdata[8*cnt+7:8*cnt].
  - On ram_ack with a load: place ram_rdata in byte lane cnt of the assembly register.
  - On ram_ack, cnt increments. The final byte's ack moves to DONE.
  - Without ram_ack, all RAM outputs hold unchanged.
- DONE: in_ready=0, ram_req=0.
  - Loads: wdata_o = assembled value; LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend. we_o=we_i as captured.
  - Stores: we_o=0.
  - Return to IDLE.
- When not retiring, we_o=0. waddr_o and wdata_o hold their last values.
- Loads with waddr_i=0 still complete the access. The register file ignores x0.
- rst in any state: FSM to IDLE, cnt=0, ram_req=0. A partially performed store is abandoned, with no rollback.

## Timing
- Reset values: in_ready=1 (combinational from IDLE), ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0, waddr_o=0, we_o=0, wdata_o=0, misalign=0.
- Non-memory instruction: accepted at edge t, outputs valid after edge t+1 for one cycle. Latency is 1; throughput is 1 per cycle.
- Memory instruction with zero-wait RAM (ack in the same cycle as req):
  - Latency is nbytes+2 cycles from acceptance to the we_o pulse.
  - in_ready is low for nbytes+1 cycles.
- Each RAM wait cycle adds one cycle of latency.
- ram_req stays continuously high across bytes. The address advances the cycle after each ack.
- ram_ack while ram_req=0 is ignored.
- RAM outputs and the FSM are registered. in_ready depends only on state.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - A halfword access with addr[0]=1 or a word access with addr[1:0]≠0 is not performed.
  - The stage pulses misalign for one cycle, one cycle after acceptance. we_o=0 for that instruction.
  - The stage remains in IDLE, so in_ready never drops.
- MEM_MISALIGN_TRAP_EN undefined: the misalign port is absent and misaligned accesses proceed bytewise from addr.

## Test plan
- Non-memory instruction: waddr_i=5, we_i=1, wdata_i=0x1234_5678, memop=0 -> next cycle we_o=1, waddr_o=5, wdata_o=0x1234_5678; following cycle we_o=0.
- SW: addr=0x100, sdata=0xAABB_CCDD, zero-wait ack -> byte writes DD@0x100, CC@0x101, BB@0x102, AA@0x103 on consecutive cycles; we_o stays 0; in_ready low 5 cycles.
- LB/LBU: addr=0x200 returns 0x80 -> LB gives wdata_o=0xFFFF_FF80, LBU gives 0x0000_0080; LH of bytes 0x34,0x92 gives 0xFFFF_9234.
- LW with ack delayed 2 cycles per byte: bytes 0x11,0x22,0x33,0x44 -> wdata_o=0x4433_2211; ram_addr stable during waits; total latency 14 cycles.
- Reset asserted in XFER after byte 1 of SW -> next cycle ram_req=0, in_ready=1, we_o=0; a subsequent LB completes normally.
- MEM_MISALIGN_TRAP_EN defined: LW at addr=0x102 -> misalign pulses once, ram_req never asserts, we_o=0. MEM_MISALIGN_TRAP_EN undefined: same LW reads 0x102-0x105.
